// File: rtl/stage_3_ex_mext_if.sv
// EX-stage M-extension unit bundle: issue side from EX, result side to EX/MEM.
// The EX pipeline drives the master side; the multiply/divide unit is the slave.
interface stage_3_ex_mext_if #(
    parameter int XLEN = 32
);
    logic              start;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rs1_out;
    logic [XLEN-1:0]   rs2_out;
    logic              flush;
    logic              advance;
    logic              stall_out;
    logic [2*XLEN-1:0] mext_out;
    logic              mext_valid;

    modport master (
        output start, funct3, rs1_out, rs2_out, flush, advance,
        input  stall_out, mext_out, mext_valid
    );

    modport slave (
        input  start, funct3, rs1_out, rs2_out, flush, advance,
        output stall_out, mext_out, mext_valid
    );
endinterface

// File: rtl/stage_3_ex_mext.sv
// Iterative RV32M multiply/divide unit, radix-2 (one bit per cycle).
// Works on magnitudes; signs are re-applied when the last iteration completes.
module stage_3_ex_mext #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    stage_3_ex_mext_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_opd;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_mul;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_fast;
    logic              r_div0;
    logic [2*XLEN-1:0] r_out;

    logic [2:0]        w_fn;
    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_b;
    logic              w_mul;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;

    assign w_fn    = bus.funct3;
    assign w_a     = bus.rs1_out;
    assign w_b     = bus.rs2_out;
    assign w_mul   = !w_fn[2];
    assign w_sgn_a = w_mul ? (w_fn != 3'b011) : !w_fn[0];
    assign w_sgn_b = w_mul ? !w_fn[1] : !w_fn[0];
    assign w_neg_a = w_sgn_a & w_a[XLEN-1];
    assign w_neg_b = w_sgn_b & w_b[XLEN-1];
    assign w_abs_a = w_neg_a ? -w_a : w_a;
    assign w_abs_b = w_neg_b ? -w_b : w_b;
    assign w_div0  = !w_mul && (w_b == '0);
    assign w_ovf   = !w_mul && !w_fn[0]
                   && (w_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (w_b == {XLEN{1'b1}});

    // mul: {hi,lo} is {partial product, remaining multiplier bits}
    // div: {hi,lo} is {partial remainder, dividend/quotient shift register}
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_nhi;
    logic [XLEN-1:0]   w_nlo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [2*XLEN-1:0] w_final;
    logic [XLEN-1:0]   w_dvd;
    logic [2*XLEN-1:0] w_fast_res;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    assign w_sh    = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = (w_sh >= {1'b0, r_opd});
    assign w_diff  = w_sh[XLEN-1:0] - r_opd;
    assign w_nhi   = r_mul ? w_sum[XLEN:1]
                   : (w_ge ? w_diff : w_sh[XLEN-1:0]);
    assign w_nlo   = r_mul ? {w_sum[0], r_lo[XLEN-1:1]}
                   : {r_lo[XLEN-2:0], w_ge};
    assign w_prod  = {w_nhi, w_nlo};
    assign w_quo   = r_neg_q ? -w_nlo : w_nlo;
    assign w_rem   = r_neg_r ? -w_nhi : w_nhi;
    assign w_final = r_mul ? (r_neg_q ? -w_prod : w_prod)
                   : {w_rem, w_quo};

    // Fast path: r_lo still holds |dividend| from the latch cycle
    assign w_dvd      = r_neg_r ? -r_lo : r_lo;
    assign w_fast_res = r_div0 ? {w_dvd, {XLEN{1'b1}}}
                      : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};

    assign bus.stall_out  = !bus.flush
                          && ((r_state == S_IDLE && bus.start)
                              || r_state == S_CALC);
    assign bus.mext_valid = !bus.flush && (r_state == S_DONE);
    assign bus.mext_out   = r_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_opd   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mul   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_fast  <= 1'b0;
            r_div0  <= 1'b0;
            r_out   <= '0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mul   <= w_mul;
                        r_opd   <= w_mul ? w_abs_a : w_abs_b;
                        r_lo    <= w_mul ? w_abs_b : w_abs_a;
                        r_hi    <= '0;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_fast  <= w_div0 | w_ovf;
                        r_div0  <= w_div0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_fast) begin
                        r_out   <= w_fast_res;
                        r_state <= S_DONE;
                    end else begin
                        r_hi  <= w_nhi;
                        r_lo  <= w_nlo;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_out   <= w_final;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.advance) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage_3_ex_mext.sv
// Scoreboard bench for stage_3_ex_mext: driver queues model results,
// a negedge monitor pops one per result presentation.
module tb_stage_3_ex_mext;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    stage_3_ex_mext_if bus ();

    stage_3_ex_mext dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    function automatic logic [63:0] model(input logic [2:0] fn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb2, ua, ub, p, q, r;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        p   = 0;
        case (fn)
            3'd0, 3'd1: p = sa * sb2;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (!fn[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
                    return {32'h0, 32'h80000000};
                if (!fn[0]) begin
                    q = sa / sb2;
                    r = sa % sb2;
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                end
                return {r[31:0], q[31:0]};
            end
        endcase
        return p;
    endfunction

    function automatic int lat_of(input logic [2:0] fn,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        if (fn[2] && (b == 32'd0 || (!fn[0] && a == 32'h80000000
                                     && b == 32'hFFFFFFFF)))
            return 2;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for its result, hold DONE, then advance.
    task automatic run_op(input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        exp_t        e;
        logic [63:0] r;
        int          n;
        bus.start   = 1'b1;
        bus.funct3  = fn;
        bus.rs1_out = a;
        bus.rs2_out = b;
        bus.advance = 1'b0;
        r     = model(fn, a, b);
        e.res = r;
        e.lat = lat_of(fn, a, b);
        e.t0  = cyc;
        sb.push_back(e);
        #1 chk("stall_at_start", 64'(bus.stall_out), 64'd1);
        @(posedge clk); #1;
        bus.rs1_out = $urandom;
        bus.rs2_out = $urandom;
        n = 1;
        while (!bus.mext_valid && n < 40) begin
            chk("stall_busy", 64'(bus.stall_out), 64'd1);
            @(posedge clk); #1;
            n++;
        end
        if (!bus.mext_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no mext_valid after %0d cycles", n);
            report();
        end
        for (int i = 0; i <= hold; i++) begin
            chk("hold_out", bus.mext_out, r);
            chk("hold_stall", 64'(bus.stall_out), 64'd0);
            chk("hold_valid", 64'(bus.mext_valid), 64'd1);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.advance = 1'b0;
        bus.start   = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mext_valid && !prev) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got %h want none",
                             bus.mext_out);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.mext_out, e.res);
                    chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                end
            end
            prev = bus.mext_valid;
        end
    end

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.funct3  = 3'd0;
        bus.rs1_out = 32'd0;
        bus.rs2_out = 32'd0;
        bus.flush   = 1'b0;
        bus.advance = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", bus.mext_out, 64'd0);
        chk("rst_stall", 64'(bus.stall_out), 64'd0);
        chk("rst_valid", 64'(bus.mext_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'd1, 0);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 0);
        run_op(3'd7, 32'd7, 32'd0, 0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1);
        run_op(3'd0, 32'h00012345, 32'h00000678, 5);
        run_op(3'd5, 32'hDEADBEEF, 32'h00001234, 0);
        run_op(3'd6, 32'hDEADBEEF, 32'h00001234, 0);

        // squash mid-iteration at count 10
        bus.start   = 1'b1;
        bus.funct3  = 3'd5;
        bus.rs1_out = $urandom;
        bus.rs2_out = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", 64'(bus.stall_out), 64'd0);
        chk("flush_valid", 64'(bus.mext_valid), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("post_flush_stall", 64'(bus.stall_out), 64'd0);
        chk("post_flush_valid", 64'(bus.mext_valid), 64'd0);
        run_op(3'd4, 32'd100, 32'hFFFFFFF9, 0);

        // reset in the middle of a divide
        bus.start   = 1'b1;
        bus.funct3  = 3'd4;
        bus.rs1_out = $urandom;
        bus.rs2_out = 32'd5;
        repeat (15) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out", bus.mext_out, 64'd0);
        chk("midrst_stall", 64'(bus.stall_out), 64'd0);
        chk("midrst_valid", 64'(bus.mext_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  fn;
            logic [31:0] a;
            logic [31:0] b;
            fn = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(fn, a, b, $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("drained", 64'(sb.size()), 64'd0);
        report();
    end
endmodule
